ptr_sync_multi: RTL and testbench

Parametrised multi-channel Gray-pointer synchroniser into the W_CLK domain, the next-generation successor of the fixed two-flop pointer synchroniser. It carries N_CH Gray-coded pointers from foreign clock domains through a configurable-depth flop chain. Per channel it also provides a registered Gray-to-binary decode, a change-strobe and an optional sticky Gray-discipline error flag. It sits on the write side of the multi-port async FIFOs and feeds full/almost-full logic directly with binary pointers.

---
 rtl/ptr_sync_pkg.sv | 20 ++
 rtl/ptr_sync_multi_if.sv | 11 +
 rtl/ptr_sync_chan.sv | 58 +++++
 rtl/ptr_sync_multi.sv | 30 +++
 tb/tb_ptr_sync_multi.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/ptr_sync_pkg.sv
// ptr_sync_pkg: shared limits and helpers for the multi-channel Gray pointer synchroniser.
package ptr_sync_pkg;
   localparam int MIN_STAGES = 2;
   localparam int MAX_STAGES = 4;
   localparam int MAX_CH     = 8;
   localparam int MAX_PW     = 32;
   // Narrower pointers are zero-extended; leading zeros do not disturb the decode.
   function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] g);
      logic [MAX_PW-1:0] b;
      b[MAX_PW-1] = g[MAX_PW-1];
      for (int i = MAX_PW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
   function automatic int unsigned popcount(input logic [MAX_PW-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < MAX_PW; i++) n = n + 32'(v[i]);
      return n;
   endfunction
endpackage

// File: rtl/ptr_sync_multi_if.sv
// ptr_sync_multi_if: packed pointer buses between foreign-domain sources and the W_CLK-side synchroniser.
interface ptr_sync_multi_if #(parameter int N_CH = 1, parameter int PW = 4) ();
   logic [N_CH*PW-1:0] ASYNC_PTR;
   logic               ERR_CLR;
   logic [N_CH*PW-1:0] SYNC_GRAY;
   logic [N_CH*PW-1:0] SYNC_BIN;
   logic [N_CH-1:0]    PTR_UPD;
   logic [N_CH-1:0]    GRAY_ERR;
   modport master (output ASYNC_PTR, ERR_CLR, input SYNC_GRAY, SYNC_BIN, PTR_UPD, GRAY_ERR);
   modport slave  (input ASYNC_PTR, ERR_CLR, output SYNC_GRAY, SYNC_BIN, PTR_UPD, GRAY_ERR);
endinterface

// File: rtl/ptr_sync_chan.sv
// ptr_sync_chan: one pointer channel - synchroniser chain, registered binary decode, change strobe and Gray checker.
module ptr_sync_chan
   import ptr_sync_pkg::*;
#(
   parameter int PW          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CHECK_GRAY  = 0
) (
   input  logic          W_CLK,
   input  logic          W_RST,
   input  logic          ERR_CLR,
   input  logic [PW-1:0] ASYNC_PTR,
   output logic [PW-1:0] SYNC_GRAY,
   output logic [PW-1:0] SYNC_BIN,
   output logic          PTR_UPD,
   output logic          GRAY_ERR
);
   if (SYNC_STAGES < MIN_STAGES || SYNC_STAGES > MAX_STAGES) begin : g_bad_stages
      $error("ptr_sync_chan: SYNC_STAGES out of range");
   end
   if (PW > MAX_PW) begin : g_bad_pw
      $error("ptr_sync_chan: pointer too wide");
   end
   (* ASYNC_REG = "TRUE" *) logic [PW-1:0] stage_q [SYNC_STAGES];
   logic [PW-1:0]     bin_d, bin_q, prev_gray;
   logic [MAX_PW-1:0] gray_w;
   logic              upd_d, upd_q, primed_d, primed_q, err_d, err_q, jump;
   assign SYNC_GRAY = stage_q[SYNC_STAGES-1];
   assign SYNC_BIN  = bin_q;
   assign PTR_UPD   = upd_q;
   assign GRAY_ERR  = err_q;
   // bin_q still holds the previous value, so its Gray re-encode is the previous synchronised pointer.
   always_comb begin
      gray_w    = MAX_PW'(SYNC_GRAY);
      bin_d     = PW'(gray2bin(gray_w));
      prev_gray = bin_q ^ (bin_q >> 1);
      upd_d     = bin_d != bin_q;
      jump      = popcount(MAX_PW'(SYNC_GRAY ^ prev_gray)) > 1;
      primed_d  = primed_q | upd_d;
      err_d     = (CHECK_GRAY != 0) && ((upd_d && primed_q && jump) || (err_q && !ERR_CLR));
   end
   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         for (int k = 0; k < SYNC_STAGES; k++) stage_q[k] <= '0;
         bin_q    <= '0;
         upd_q    <= 1'b0;
         primed_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         stage_q[0] <= ASYNC_PTR;
         for (int k = 1; k < SYNC_STAGES; k++) stage_q[k] <= stage_q[k-1];
         bin_q    <= bin_d;
         upd_q    <= upd_d;
         primed_q <= primed_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: rtl/ptr_sync_multi.sv
// ptr_sync_multi: N_CH independent Gray pointer synchronisers into W_CLK; this level only slices and packs buses.
module ptr_sync_multi
   import ptr_sync_pkg::*;
#(
   parameter int ADDRESS_BITS = 3,
   parameter int N_CH         = 1,
   parameter int SYNC_STAGES  = 2,
   parameter int CHECK_GRAY   = 0
) (
   input  logic          W_CLK,
   input  logic          W_RST,
   ptr_sync_multi_if.slave bus
);
   localparam int PW = ADDRESS_BITS + 1;
   if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_ch
      $error("ptr_sync_multi: N_CH out of range");
   end
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      ptr_sync_chan #(.PW(PW), .SYNC_STAGES(SYNC_STAGES), .CHECK_GRAY(CHECK_GRAY)) u_chan (
         .W_CLK     (W_CLK),
         .W_RST     (W_RST),
         .ERR_CLR   (bus.ERR_CLR),
         .ASYNC_PTR (bus.ASYNC_PTR[c*PW +: PW]),
         .SYNC_GRAY (bus.SYNC_GRAY[c*PW +: PW]),
         .SYNC_BIN  (bus.SYNC_BIN[c*PW +: PW]),
         .PTR_UPD   (bus.PTR_UPD[c]),
         .GRAY_ERR  (bus.GRAY_ERR[c])
      );
   end
endmodule

// File: tb/tb_ptr_sync_multi.sv
// tb_ptr_sync_multi: scoreboarded bench over a 4-channel checking instance and two deeper single-channel instances.
module tb_ptr_sync_multi;
   typedef struct {
      int       ch;
      logic [3:0] bin;
      logic     err;
      int       cyc;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   ptr_sync_multi_if #(.N_CH(4), .PW(4)) b0 ();
   ptr_sync_multi_if #(.N_CH(1), .PW(4)) b1 ();
   ptr_sync_multi_if #(.N_CH(1), .PW(4)) b2 ();
   ptr_sync_multi #(.ADDRESS_BITS(3), .N_CH(4), .SYNC_STAGES(2), .CHECK_GRAY(1)) d0 (.W_CLK(clk), .W_RST(rst_n), .bus(b0));
   ptr_sync_multi #(.ADDRESS_BITS(3), .N_CH(1), .SYNC_STAGES(3), .CHECK_GRAY(0)) d1 (.W_CLK(clk), .W_RST(rst_n), .bus(b1));
   ptr_sync_multi #(.ADDRESS_BITS(3), .N_CH(1), .SYNC_STAGES(4), .CHECK_GRAY(0)) d2 (.W_CLK(clk), .W_RST(rst_n), .bus(b2));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic cmp(input string tag, input int c, input exp_t e, input logic [3:0] bin, input logic err);
      chk({tag, " channel"}, c, e.ch);
      chk({tag, " SYNC_BIN"}, int'(bin), int'(e.bin));
      chk({tag, " GRAY_ERR"}, int'(err), int'(e.err));
      chk({tag, " latency"}, cyc, e.cyc);
   endtask
   task automatic stray(input string tag, input int c);
      n_chk++;
      n_err++;
      $display("FAIL %s unexpected PTR_UPD ch%0d: got 1 expected 0 (cycle %0d)", tag, c, cyc);
   endtask
   // Monitor: every strobe must match the oldest outstanding expectation of its instance.
   always @(negedge clk) begin
      exp_t e;
      for (int c = 0; c < 4; c++) begin
         if (b0.PTR_UPD[c] === 1'b1) begin
            if (q0.size() == 0) stray("d0", c);
            else begin
               e = q0.pop_front();
               cmp("d0", c, e, b0.SYNC_BIN[c*4 +: 4], b0.GRAY_ERR[c]);
            end
         end
      end
      if (b1.PTR_UPD[0] === 1'b1) begin
         if (q1.size() == 0) stray("d1", 0);
         else begin
            e = q1.pop_front();
            cmp("d1", 0, e, b1.SYNC_BIN, b1.GRAY_ERR[0]);
         end
      end
      if (b2.PTR_UPD[0] === 1'b1) begin
         if (q2.size() == 0) stray("d2", 0);
         else begin
            e = q2.pop_front();
            cmp("d2", 0, e, b2.SYNC_BIN, b2.GRAY_ERR[0]);
         end
      end
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic exp0(input int c, input logic [3:0] bin, input logic err, input int lat);
      q0.push_back('{c, bin, err, cyc + lat});
   endtask
   initial begin
      b0.ASYNC_PTR = '0;
      b0.ERR_CLR   = 1'b0;
      b1.ASYNC_PTR = '0;
      b1.ERR_CLR   = 1'b0;
      b2.ASYNC_PTR = '0;
      b2.ERR_CLR   = 1'b0;
      #1 rst_n = 1'b0;
      b0.ASYNC_PTR[3:0] = 4'b0110;
      tick(3);
      chk("reset SYNC_GRAY", int'(b0.SYNC_GRAY), 0);
      chk("reset SYNC_BIN", int'(b0.SYNC_BIN), 0);
      chk("reset PTR_UPD", int'(b0.PTR_UPD), 0);
      chk("reset GRAY_ERR", int'(b0.GRAY_ERR), 0);
      rst_n = 1'b1;
      exp0(0, 4'b0100, 1'b0, 3);
      tick(2);
      chk("release SYNC_GRAY at edge 2", int'(b0.SYNC_GRAY[3:0]), 6);
      chk("release SYNC_BIN before edge 3", int'(b0.SYNC_BIN[3:0]), 0);
      tick(3);
      // Full wrap on channel 1: bin 1..15 then back to 0 (Gray 1000 -> 0000).
      for (int k = 1; k <= 16; k++) begin
         logic [3:0] b;
         b = 4'(k);
         b0.ASYNC_PTR[7:4] = b ^ (b >> 1);
         exp0(1, b, 1'b0, 3);
         tick(2);
      end
      tick(3);
      chk("wrap GRAY_ERR", int'(b0.GRAY_ERR), 0);
      // Checker on channel 2.
      b0.ASYNC_PTR[11:8] = 4'b0001;
      exp0(2, 4'b0001, 1'b0, 3);
      tick(5);
      b0.ASYNC_PTR[11:8] = 4'b0111;
      exp0(2, 4'b0101, 1'b1, 3);
      tick(5);
      chk("GRAY_ERR held", int'(b0.GRAY_ERR), 4);
      b0.ERR_CLR = 1'b1;
      tick(1);
      b0.ERR_CLR = 1'b0;
      chk("GRAY_ERR cleared", int'(b0.GRAY_ERR), 0);
      b0.ASYNC_PTR[11:8] = 4'b0100;
      exp0(2, 4'b0111, 1'b1, 3);
      tick(2);
      b0.ERR_CLR = 1'b1;
      tick(1);
      b0.ERR_CLR = 1'b0;
      tick(1);
      chk("set beats ERR_CLR", int'(b0.GRAY_ERR), 4);
      b0.ERR_CLR = 1'b1;
      tick(1);
      b0.ERR_CLR = 1'b0;
      chk("GRAY_ERR cleared again", int'(b0.GRAY_ERR), 0);
      // Depth sweep and multi-bit change with the checker disabled.
      b1.ASYNC_PTR = 4'b0001;
      b2.ASYNC_PTR = 4'b0001;
      q1.push_back('{0, 4'b0001, 1'b0, cyc + 4});
      q2.push_back('{0, 4'b0001, 1'b0, cyc + 5});
      tick(7);
      b1.ASYNC_PTR = 4'b0110;
      q1.push_back('{0, 4'b0100, 1'b0, cyc + 4});
      tick(7);
      chk("CHECK_GRAY=0 GRAY_ERR", int'(b1.GRAY_ERR), 0);
      // Simultaneous 1-bit changes on every channel.
      b0.ASYNC_PTR = {4'b1000, 4'b1100, 4'b0001, 4'b0111};
      exp0(0, 4'b0101, 1'b0, 3);
      exp0(1, 4'b0001, 1'b0, 3);
      exp0(2, 4'b1000, 1'b0, 3);
      exp0(3, 4'b1111, 1'b0, 3);
      tick(3);
      chk("multi SYNC_GRAY", int'(b0.SYNC_GRAY), 16'h8C17);
      tick(3);
      // Reset with a channel-0 change still in the chain.
      b0.ASYNC_PTR[3:0] = 4'b0101;
      tick(1);
      rst_n = 1'b0;
      #1;
      chk("async reset SYNC_GRAY", int'(b0.SYNC_GRAY), 0);
      chk("async reset SYNC_BIN", int'(b0.SYNC_BIN), 0);
      chk("async reset d1 SYNC_BIN", int'(b1.SYNC_BIN), 0);
      tick(3);
      rst_n = 1'b1;
      exp0(0, 4'b0110, 1'b0, 3);
      exp0(1, 4'b0001, 1'b0, 3);
      exp0(2, 4'b1000, 1'b0, 3);
      exp0(3, 4'b1111, 1'b0, 3);
      q1.push_back('{0, 4'b0100, 1'b0, cyc + 4});
      q2.push_back('{0, 4'b0001, 1'b0, cyc + 5});
      tick(10);
      chk("after reset GRAY_ERR", int'(b0.GRAY_ERR), 0);
      chk("d0 expectations left", q0.size(), 0);
      chk("d1 expectations left", q1.size(), 0);
      chk("d2 expectations left", q2.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
